// File: rtl/rf_writeback_scoreboard_pkg.sv
// Shared defaults and source-slot indices for the RF writeback scoreboard.
package rf_writeback_scoreboard_pkg;

  localparam int ADDR_W_DEF   = 5;
  localparam int DEPTH_DEF    = 4;
  localparam int FWD_DIST_DEF = 1;
  localparam int CNT_W_DEF    = 16;

  // Bit positions of the three operand sources within SRC_USE and the hit vectors.
  localparam int SRC_A = 0;
  localparam int SRC_B = 1;
  localparam int SRC_C = 2;
  localparam int N_SRC = 3;

endpackage

// File: rtl/rf_writeback_scoreboard_if.sv
// Issue/writeback bus between decode, the scoreboard and the RF write port.
interface rf_writeback_scoreboard_if #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic              ENABLE;
  logic              ISSUE_VALID;
  logic              ISSUE_WE;
  logic [ADDR_W-1:0] ISSUE_D;
  logic [ADDR_W-1:0] ISSUE_A;
  logic [ADDR_W-1:0] ISSUE_B;
  logic [ADDR_W-1:0] ISSUE_C;
  logic [2:0]        SRC_USE;
  logic              STALL;
  logic              FWD_HIT;
  logic              WB_EN;
  logic [ADDR_W-1:0] WB_ADDR;
  logic [2:0]        INFLIGHT;
  logic [CNT_W-1:0]  STALL_CNT;

  // Decode side: presents instructions, observes hazards and writeback.
  modport master (
    output ENABLE, ISSUE_VALID, ISSUE_WE, ISSUE_D, ISSUE_A, ISSUE_B, ISSUE_C, SRC_USE,
    input  STALL, FWD_HIT, WB_EN, WB_ADDR, INFLIGHT, STALL_CNT
  );

  // Scoreboard side.
  modport slave (
    input  ENABLE, ISSUE_VALID, ISSUE_WE, ISSUE_D, ISSUE_A, ISSUE_B, ISSUE_C, SRC_USE,
    output STALL, FWD_HIT, WB_EN, WB_ADDR, INFLIGHT, STALL_CNT
  );
endinterface

// File: rtl/rf_writeback_scoreboard_addr_cmp.sv
// Per-stage comparator: which used sources read the address held in this stage.
// Hits are reported per source so the top can pick the youngest producer per operand.
module rf_addr_cmp
  import rf_writeback_scoreboard_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              v,
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  input  logic [ADDR_W-1:0] src_c,
  input  logic [2:0]        src_use,
  output logic [2:0]        src_hit
);

  // A source hits only when the stage holds a live writer and the source is actually read.
  always_comb begin
    src_hit        = '0;
    src_hit[SRC_A] = v & src_use[SRC_A] & (addr == src_a);
    src_hit[SRC_B] = v & src_use[SRC_B] & (addr == src_b);
    src_hit[SRC_C] = v & src_use[SRC_C] & (addr == src_c);
  end

endmodule

// File: rtl/rf_writeback_scoreboard.sv
// Tracks RF destinations through the DSP pipe: drives RF writeback, flags
// forwardable sources and stalls issue on RAW hazards beyond forwarding reach.
module rf_writeback_scoreboard
  import rf_writeback_scoreboard_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int FWD_DIST = FWD_DIST_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                     CLK,
  input  logic                     RESET,
  rf_writeback_scoreboard_if.slave bus
);

  logic [DEPTH-1:0]  v_reg;
  logic [DEPTH-1:0]  v_next;
  logic [ADDR_W-1:0] addr_reg  [DEPTH];
  logic [ADDR_W-1:0] addr_next [DEPTH];
  logic [2:0]        hit       [DEPTH];
  logic [2:0]        fwd_src;
  logic [2:0]        older_src;
  logic [2:0]        stall_src;
  logic              stall;
  logic              fwd_hit;
  logic              wb_en;
  logic              entry_v;
  logic [2:0]        inflight_reg;
  logic [2:0]        inflight_next;
  logic [CNT_W-1:0]  stall_cnt_reg;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
      rf_addr_cmp #(.ADDR_W(ADDR_W)) u_cmp (
        .v       (v_reg[gi]),
        .addr    (addr_reg[gi]),
        .src_a   (bus.ISSUE_A),
        .src_b   (bus.ISSUE_B),
        .src_c   (bus.ISSUE_C),
        .src_use (bus.SRC_USE),
        .src_hit (hit[gi])
      );
    end
  endgenerate

  // Per-source hazard trees: a hit inside forwarding reach is always younger than
  // any hit beyond it, so it shadows older duplicates of the same destination.
  always_comb begin
    fwd_src   = '0;
    older_src = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < FWD_DIST) fwd_src   = fwd_src | hit[i];
      else              older_src = older_src | hit[i];
    end
  end

  assign stall_src = older_src & ~fwd_src;
  assign stall     = bus.ISSUE_VALID & (|stall_src);
  assign fwd_hit   = bus.ISSUE_VALID & (|fwd_src) & ~stall;

  // Retiring entry writes the RF only on an advancing, non-reset cycle.
  assign wb_en = bus.ENABLE & ~RESET & v_reg[DEPTH-1];

  assign bus.STALL     = stall;
  assign bus.FWD_HIT   = fwd_hit;
  assign bus.WB_EN     = wb_en;
  assign bus.WB_ADDR   = wb_en ? addr_reg[DEPTH-1] : '0;
  assign bus.INFLIGHT  = inflight_reg;
  assign bus.STALL_CNT = stall_cnt_reg;

  // Stalled or non-writing issues enter the pipe as bubbles.
  assign entry_v = bus.ISSUE_VALID & bus.ISSUE_WE & ~stall;

  // Next pipe contents: shift one stage when the pipe advances, otherwise hold.
  always_comb begin
    v_next = v_reg;
    for (int i = 0; i < DEPTH; i++) addr_next[i] = addr_reg[i];
    if (bus.ENABLE) begin
      v_next       = {v_reg[DEPTH-2:0], entry_v};
      addr_next[0] = bus.ISSUE_D;
      for (int i = 1; i < DEPTH; i++) addr_next[i] = addr_reg[i-1];
    end
  end

  // Occupancy of the pipe as it will stand after this edge.
  always_comb begin
    inflight_next = '0;
    for (int i = 0; i < DEPTH; i++) inflight_next = inflight_next + 3'(v_next[i]);
  end

  // Pipe state, occupancy and saturating stall counter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      v_reg         <= '0;
      inflight_reg  <= '0;
      stall_cnt_reg <= '0;
      for (int i = 0; i < DEPTH; i++) addr_reg[i] <= '0;
    end else begin
      v_reg        <= v_next;
      inflight_reg <= inflight_next;
      for (int i = 0; i < DEPTH; i++) addr_reg[i] <= addr_next[i];
      if (bus.ENABLE && stall && (stall_cnt_reg != '1)) stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

endmodule
